ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 39 +++
 rtl/ex_stage_alu.sv | 31 +++
 rtl/ex_stage.sv | 119 +++++++++++
 tb/tb_ex_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU op codes,
// multiplier state encoding and the EX/MEM pipeline register payload.
package ex_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned SRC_W   = 2;
    localparam int unsigned CNT_W   = 5;

    localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [OP_W-1:0] ALU_LUI = 4'd5;
    localparam logic [OP_W-1:0] ALU_SLL = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRL = 4'd7;
    localparam logic [OP_W-1:0] ALU_SRA = 4'd8;
    localparam logic [OP_W-1:0] ALU_MUL = 4'd9;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    typedef struct packed {
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  data;
        logic [XLEN-1:0]  pc4;
        logic             write_register;
        logic             write_data;
        logic [SRC_W-1:0] register_source;
        logic [REG_W-1:0] register_number;
    } ex_mem_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Single-cycle combinational ALU; op 9 (mul) and unused codes return 0.
module alu
    import ex_stage_pkg::*;
(
    input  logic [OP_W-1:0] operation,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [SHAMT_W-1:0] shamt;
    assign shamt = a[SHAMT_W-1:0];

    // Operation decode; shifts move b by the low bits of a.
    always_comb begin
        result = '0;
        case (operation)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_LUI: result = b << 16;
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_SRA: result = XLEN'($signed(b) >>> shamt);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, optional iterative multiplier and the EX/MEM register.
// Define EX_STAGE_MUL_EN to build the 32-step shift-add multiplier (op 9);
// without it op 9 returns 0 and busy is tied low.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [OP_W-1:0]  id_ex_alu_operation,
    input  logic [XLEN-1:0]  id_ex_alu_parameter1,
    input  logic [XLEN-1:0]  id_ex_alu_parameter2,
    input  logic             id_ex_write_register,
    input  logic             id_ex_write_data,
    input  logic [SRC_W-1:0] id_ex_register_source,
    input  logic [REG_W-1:0] id_ex_register_number,
    input  logic [XLEN-1:0]  id_ex_data,
    input  logic [XLEN-1:0]  id_ex_pc4,
    output logic [XLEN-1:0]  forward_data,
    output logic             busy,
    output logic [XLEN-1:0]  ex_mem_alu_result,
    output logic [XLEN-1:0]  ex_mem_data,
    output logic [XLEN-1:0]  ex_mem_pc4,
    output logic             ex_mem_write_register,
    output logic             ex_mem_write_data,
    output logic [SRC_W-1:0] ex_mem_register_source,
    output logic [REG_W-1:0] ex_mem_register_number
);

    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] result;
    ex_mem_t         ex_mem_q;

    alu u_alu (
        .operation (id_ex_alu_operation),
        .a         (id_ex_alu_parameter1),
        .b         (id_ex_alu_parameter2),
        .result    (alu_result)
    );

`ifdef EX_STAGE_MUL_EN
    mul_state_t       state_q;
    logic [CNT_W-1:0] count_q;
    logic [XLEN-1:0]  multiplicand_q;
    logic [XLEN-1:0]  multiplier_q;
    logic [XLEN-1:0]  product_q;

    // Shift-add multiplier: latch in IDLE, 32 accumulate steps in RUN, present in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= MUL_IDLE;
            count_q        <= '0;
            multiplicand_q <= '0;
            multiplier_q   <= '0;
            product_q      <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (id_ex_alu_operation == ALU_MUL) begin
                        multiplicand_q <= id_ex_alu_parameter1;
                        multiplier_q   <= id_ex_alu_parameter2;
                        product_q      <= '0;
                        count_q        <= '0;
                        state_q        <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    if (multiplier_q[0]) begin
                        product_q <= product_q + multiplicand_q;
                    end
                    multiplicand_q <= multiplicand_q << 1;
                    multiplier_q   <= multiplier_q >> 1;
                    count_q        <= count_q + CNT_W'(1);
                    if (count_q == CNT_W'(XLEN - 1)) begin
                        state_q <= MUL_DONE;
                    end
                end
                MUL_DONE: state_q <= MUL_IDLE;
                default:  state_q <= MUL_IDLE;
            endcase
        end
    end

    // Stall decode while a mul is pending; reset releases the stall immediately.
    assign busy   = ~reset && (id_ex_alu_operation == ALU_MUL) && (state_q != MUL_DONE);
    assign result = ((id_ex_alu_operation == ALU_MUL) && (state_q == MUL_DONE))
                    ? product_q : alu_result;
`else
    assign busy   = 1'b0;
    assign result = alu_result;
`endif

    assign forward_data = result;

    // EX/MEM register: bubble while stalled, otherwise capture result and sidebands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_mem_q <= '0;
        end else if (busy) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q.alu_result      <= result;
            ex_mem_q.data            <= id_ex_data;
            ex_mem_q.pc4             <= id_ex_pc4;
            ex_mem_q.write_register  <= id_ex_write_register;
            ex_mem_q.write_data      <= id_ex_write_data;
            ex_mem_q.register_source <= id_ex_register_source;
            ex_mem_q.register_number <= id_ex_register_number;
        end
    end

    assign ex_mem_alu_result      = ex_mem_q.alu_result;
    assign ex_mem_data            = ex_mem_q.data;
    assign ex_mem_pc4             = ex_mem_q.pc4;
    assign ex_mem_write_register  = ex_mem_q.write_register;
    assign ex_mem_write_data      = ex_mem_q.write_data;
    assign ex_mem_register_source = ex_mem_q.register_source;
    assign ex_mem_register_number = ex_mem_q.register_number;

endmodule

// File: tb/tb_ex_stage.sv
// Directed, table-driven bench for ex_stage, with hand sequences for the
// multi-cycle multiplier and reset cases (build-dependent on EX_STAGE_MUL_EN).
module tb_ex_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  op = '0;
    logic [31:0] pa = '0;
    logic [31:0] pb = '0;
    logic        wr = 1'b0;
    logic        wd = 1'b0;
    logic [1:0]  src = '0;
    logic [4:0]  num = '0;
    logic [31:0] sdata = '0;
    logic [31:0] pc4 = '0;

    logic [31:0] forward_data;
    logic        busy;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_data;
    logic [31:0] ex_mem_pc4;
    logic        ex_mem_write_register;
    logic        ex_mem_write_data;
    logic [1:0]  ex_mem_register_source;
    logic [4:0]  ex_mem_register_number;

    int n_cmp = 0;
    int n_bad = 0;

    ex_stage dut (
        .clock                  (clock),
        .reset                  (reset),
        .id_ex_alu_operation    (op),
        .id_ex_alu_parameter1   (pa),
        .id_ex_alu_parameter2   (pb),
        .id_ex_write_register   (wr),
        .id_ex_write_data       (wd),
        .id_ex_register_source  (src),
        .id_ex_register_number  (num),
        .id_ex_data             (sdata),
        .id_ex_pc4              (pc4),
        .forward_data           (forward_data),
        .busy                   (busy),
        .ex_mem_alu_result      (ex_mem_alu_result),
        .ex_mem_data            (ex_mem_data),
        .ex_mem_pc4             (ex_mem_pc4),
        .ex_mem_write_register  (ex_mem_write_register),
        .ex_mem_write_data      (ex_mem_write_data),
        .ex_mem_register_source (ex_mem_register_source),
        .ex_mem_register_number (ex_mem_register_number)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        wr;
        logic        wd;
        logic [1:0]  src;
        logic [4:0]  num;
        logic [31:0] data;
        logic [31:0] pc4;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        op = v.op; pa = v.a; pb = v.b; wr = v.wr; wd = v.wd;
        src = v.src; num = v.num; sdata = v.data; pc4 = v.pc4;
    endtask

    task automatic check_ex_mem_zero(input string tag);
        check({tag, " ex_mem_alu_result"}, ex_mem_alu_result, 32'h0);
        check({tag, " ex_mem_write_register"}, 32'(ex_mem_write_register), 32'h0);
        check({tag, " ex_mem_write_data"}, 32'(ex_mem_write_data), 32'h0);
        check({tag, " ex_mem_register_number"}, 32'(ex_mem_register_number), 32'h0);
        check({tag, " ex_mem_data"}, ex_mem_data, 32'h0);
        check({tag, " ex_mem_pc4"}, ex_mem_pc4, 32'h0);
        check({tag, " ex_mem_register_source"}, 32'(ex_mem_register_source), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int   cycles;

        //         op     a             b             wr    wd    src    num    data          pc4           expected
        vecs[0]  = '{4'd0, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 2'd0, 5'd3,  32'hAAAA0001, 32'h00000104, 32'h80000000};
        vecs[1]  = '{4'd0, 32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b0, 2'd1, 5'd31, 32'h00000000, 32'h00000108, 32'h00000001};
        vecs[2]  = '{4'd1, 32'h00000005, 32'h00000007, 1'b1, 1'b0, 2'd0, 5'd4,  32'h12345678, 32'h0000010C, 32'hFFFFFFFE};
        vecs[3]  = '{4'd1, 32'h00000010, 32'h00000003, 1'b0, 1'b1, 2'd0, 5'd0,  32'hDEADBEEF, 32'h00000110, 32'h0000000D};
        vecs[4]  = '{4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0, 2'd2, 5'd7,  32'h00000000, 32'h00000114, 32'h00F000F0};
        vecs[5]  = '{4'd3, 32'hF0F00000, 32'h0000F0F0, 1'b1, 1'b1, 2'd3, 5'd9,  32'h55555555, 32'h00000118, 32'hF0F0F0F0};
        vecs[6]  = '{4'd4, 32'hFFFF0000, 32'hFF00FF00, 1'b1, 1'b0, 2'd0, 5'd10, 32'h00000000, 32'h0000011C, 32'h00FFFF00};
        vecs[7]  = '{4'd5, 32'hFFFFFFFF, 32'h00001234, 1'b1, 1'b0, 2'd0, 5'd11, 32'h00000000, 32'h00000120, 32'h12340000};
        vecs[8]  = '{4'd6, 32'h00000004, 32'h00000001, 1'b1, 1'b0, 2'd0, 5'd12, 32'h00000000, 32'h00000124, 32'h00000010};
        vecs[9]  = '{4'd6, 32'h00000024, 32'h0000000F, 1'b1, 1'b0, 2'd0, 5'd13, 32'h00000000, 32'h00000128, 32'h000000F0};
        vecs[10] = '{4'd7, 32'h00000004, 32'hF0000000, 1'b1, 1'b0, 2'd0, 5'd14, 32'h00000000, 32'h0000012C, 32'h0F000000};
        vecs[11] = '{4'd8, 32'h00000004, 32'hF0000000, 1'b1, 1'b0, 2'd0, 5'd15, 32'h00000000, 32'h00000130, 32'hFF000000};
        vecs[12] = '{4'd8, 32'h0000001F, 32'h80000000, 1'b1, 1'b0, 2'd0, 5'd16, 32'h00000000, 32'h00000134, 32'hFFFFFFFF};
        vecs[13] = '{4'd10, 32'h00000003, 32'h00000004, 1'b1, 1'b0, 2'd0, 5'd17, 32'h00000000, 32'h00000138, 32'h00000000};
        vecs[14] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 2'd1, 5'd18, 32'h00000009, 32'h0000013C, 32'h00000000};
        vecs[15] = '{4'd0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 2'd0, 5'd0,  32'h00000000, 32'h00000000, 32'h00000000};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_ex_mem_zero("reset");
        check("reset busy", 32'(busy), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Single-op vectors: same-cycle forward, then one-edge EX/MEM capture
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d forward_data", i), forward_data, vecs[i].exp);
            check($sformatf("v%0d busy", i), 32'(busy), 32'h0);
            @(posedge clock);
            #1;
            check($sformatf("v%0d ex_mem_alu_result", i), ex_mem_alu_result, vecs[i].exp);
            check($sformatf("v%0d ex_mem_write_register", i), 32'(ex_mem_write_register), 32'(vecs[i].wr));
            check($sformatf("v%0d ex_mem_write_data", i), 32'(ex_mem_write_data), 32'(vecs[i].wd));
            check($sformatf("v%0d ex_mem_register_source", i), 32'(ex_mem_register_source), 32'(vecs[i].src));
            check($sformatf("v%0d ex_mem_register_number", i), 32'(ex_mem_register_number), 32'(vecs[i].num));
            check($sformatf("v%0d ex_mem_data", i), ex_mem_data, vecs[i].data);
            check($sformatf("v%0d ex_mem_pc4", i), ex_mem_pc4, vecs[i].pc4);
        end

`ifdef EX_STAGE_MUL_EN
        // Full multiply: 33 busy cycles with bubbles, then product captured in DONE
        @(negedge clock);
        v = '{4'd9, 32'h00010003, 32'h00020005, 1'b1, 1'b0, 2'd1, 5'd21, 32'h0000BEEF, 32'h00000200, 32'h000B000F};
        drive(v);
        #1;
        check("mul busy start", 32'(busy), 32'h1);
        cycles = 0;
        while (busy && cycles < 100) begin
            @(posedge clock);
            #1;
            cycles++;
            check($sformatf("mul c%0d bubble wr", cycles), 32'(ex_mem_write_register), 32'h0);
            check($sformatf("mul c%0d bubble result", cycles), ex_mem_alu_result, 32'h0);
            check($sformatf("mul c%0d bubble num", cycles), 32'(ex_mem_register_number), 32'h0);
        end
        check("mul busy cycles", 32'(cycles), 32'd33);
        check("mul done forward_data", forward_data, 32'h000B000F);
        @(posedge clock);
        #1;
        drive(vecs[15]);
        check("mul ex_mem_alu_result", ex_mem_alu_result, 32'h000B000F);
        check("mul ex_mem_write_register", 32'(ex_mem_write_register), 32'h1);
        check("mul ex_mem_register_source", 32'(ex_mem_register_source), 32'h1);
        check("mul ex_mem_register_number", 32'(ex_mem_register_number), 32'd21);
        check("mul ex_mem_data", ex_mem_data, 32'h0000BEEF);
        check("mul ex_mem_pc4", ex_mem_pc4, 32'h00000200);
        #1;
        check("mul idle busy", 32'(busy), 32'h0);

        // Reset at RUN step 10 aborts the multiply at once
        @(negedge clock);
        drive(v);
        repeat (11) @(posedge clock);
        @(negedge clock);
        check("abort busy before reset", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'h0);
        check("abort forward_data", forward_data, 32'h0);
        check_ex_mem_zero("abort");
        @(negedge clock);
        v = '{4'd0, 32'h00000002, 32'h00000003, 1'b1, 1'b0, 2'd0, 5'd5, 32'h0, 32'h00000300, 32'h00000005};
        drive(v);
        reset = 1'b0;
        #1;
        check("post-abort forward_data", forward_data, 32'h5);
        check("post-abort busy", 32'(busy), 32'h0);
        @(posedge clock);
        #1;
        check("post-abort ex_mem_alu_result", ex_mem_alu_result, 32'h5);
        check("post-abort ex_mem_register_number", 32'(ex_mem_register_number), 32'd5);
`else
        // Without the multiplier op 9 is an ordinary zero-result op
        @(negedge clock);
        v = '{4'd9, 32'h00010003, 32'h00020005, 1'b1, 1'b0, 2'd0, 5'd21, 32'h0000BEEF, 32'h00000200, 32'h00000000};
        drive(v);
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("nomul c%0d busy", c), 32'(busy), 32'h0);
            check($sformatf("nomul c%0d forward_data", c), forward_data, 32'h0);
            @(posedge clock);
            #1;
            check($sformatf("nomul c%0d ex_mem_alu_result", c), ex_mem_alu_result, 32'h0);
            check($sformatf("nomul c%0d ex_mem_register_number", c), 32'(ex_mem_register_number), 32'd21);
            @(negedge clock);
        end

        // Mid-stream reset clears the pipeline register, then add 2+3
        reset = 1'b1;
        #1;
        check_ex_mem_zero("midreset");
        check("midreset busy", 32'(busy), 32'h0);
        @(negedge clock);
        v = '{4'd0, 32'h00000002, 32'h00000003, 1'b1, 1'b0, 2'd0, 5'd5, 32'h0, 32'h00000300, 32'h00000005};
        drive(v);
        reset = 1'b0;
        #1;
        check("post-reset forward_data", forward_data, 32'h5);
        @(posedge clock);
        #1;
        check("post-reset ex_mem_alu_result", ex_mem_alu_result, 32'h5);
        check("post-reset ex_mem_pc4", ex_mem_pc4, 32'h00000300);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
